// File: rtl/decode_pkg.sv
// Shared types for the decode stage: opcodes, ALU operations, immediate formats,
// result-source selection and the packed control bundle handed to execute.
package decode_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        alu_op_e     alu_ctrl;
        logic        alu_src;
        imm_src_e    imm_src;
        result_src_e result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write:  1'b0,
        alu_ctrl:   ALU_ADD,
        alu_src:    1'b0,
        imm_src:    IMM_I,
        result_src: RES_ALU,
        mem_write:  1'b0,
        branch:     1'b0,
        jump:       1'b0,
        illegal:    1'b0
    };

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate from an instruction
// word and sign-extends it from bit 31 to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_ext
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_src)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Size cast of a signed value sign-extends into the upper XLEN bits.
    assign imm_ext = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Pipelined RV32I decode stage: IF/ID register, main decoder, immediate
// generation and optional ID/EX register (OUT_REG). RV32M decode under DECODE_MEXT_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OUT_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic            RegWrite,
    output logic [4:0]      ALUctrl,
    output logic            ALUsrc,
    output logic [2:0]      ImmSrc,
    output logic [1:0]      ResultSrc,
    output logic            MemWrite,
    output logic            Branch,
    output logic            Jump,
    output logic [2:0]      funct3_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] ImmExt,
    output logic            illegal_o
);

    logic            vld_p0;
    logic [XLEN-1:0] pc_p0;
    logic [31:0]     instr_p0;

    // IF/ID: flush clears valid even under stall; stall holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            pc_p0    <= '0;
            instr_p0 <= '0;
        end else if (flush_i) begin
            vld_p0   <= 1'b0;
            pc_p0    <= pc_i;
            instr_p0 <= instr_i;
        end else if (!stall_i) begin
            vld_p0   <= valid_i;
            pc_p0    <= pc_i;
            instr_p0 <= instr_i;
        end
    end

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] shamt_f7;
    ctrl_t      dec;
    logic       ill;

    assign opcode = instr_p0[6:0];
    assign funct3 = instr_p0[14:12];
    assign funct7 = instr_p0[31:25];
    // RV64 shift-immediates carry a 6-bit shamt, so bit 25 is not part of funct7.
    assign shamt_f7 = (XLEN == 64) ? {instr_p0[31:26], 1'b0} : instr_p0[31:25];

    always_comb begin
        dec = CTRL_NOP;
        ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec.alu_ctrl = ALU_ADD;
                            3'b001:  dec.alu_ctrl = ALU_SLL;
                            3'b010:  dec.alu_ctrl = ALU_SLT;
                            3'b011:  dec.alu_ctrl = ALU_SLTU;
                            3'b100:  dec.alu_ctrl = ALU_XOR;
                            3'b101:  dec.alu_ctrl = ALU_SRL;
                            3'b110:  dec.alu_ctrl = ALU_OR;
                            default: dec.alu_ctrl = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
                        else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
                        else                       ill = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    7'b0000001: dec.alu_ctrl = alu_op_e'(5'd16 + {2'b00, funct3});
`endif
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_I;
                case (funct3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        if (shamt_f7 != 7'b0000000) ill = 1'b1;
                    end
                    default: begin
                        if (shamt_f7 == 7'b0000000)      dec.alu_ctrl = ALU_SRL;
                        else if (shamt_f7 == 7'b0100000) dec.alu_ctrl = ALU_SRA;
                        else                             ill = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_I;
                dec.result_src = RES_MEM;
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_S;
            end
            OPC_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm_src  = IMM_B;
                dec.alu_ctrl = ALU_SUB;
                if (funct3 == 3'b010 || funct3 == 3'b011) ill = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.imm_src    = IMM_J;
                dec.result_src = RES_PC4;
            end
            OPC_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = IMM_I;
                dec.result_src = RES_PC4;
            end
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_ctrl  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_U;
            end
            default: ill = 1'b1;
        endcase
        // An illegal word must not cause any architectural side effect.
        if (ill) begin
            dec         = CTRL_NOP;
            dec.illegal = 1'b1;
        end
    end

    logic [XLEN-1:0] imm_raw;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (instr_p0),
        .imm_src (dec.imm_src),
        .imm_ext (imm_raw)
    );

    // Everything leaving the stage is forced to zero when the slot is empty.
    ctrl_t           ctrl_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] imm_d;
    logic [2:0]      f3_d;
    logic [4:0]      rs1_d;
    logic [4:0]      rs2_d;
    logic [4:0]      rd_d;

    assign ctrl_d = vld_p0 ? dec              : CTRL_NOP;
    assign pc_d   = vld_p0 ? pc_p0            : '0;
    assign imm_d  = vld_p0 ? imm_raw          : '0;
    assign f3_d   = vld_p0 ? funct3           : '0;
    assign rs1_d  = vld_p0 ? instr_p0[19:15]  : '0;
    assign rs2_d  = vld_p0 ? instr_p0[24:20]  : '0;
    assign rd_d   = vld_p0 ? instr_p0[11:7]   : '0;

    ctrl_t ctrl_o;

    generate
        if (OUT_REG != 0) begin : g_idex
            logic            vld_p1;
            ctrl_t           ctrl_p1;
            logic [XLEN-1:0] pc_p1;
            logic [XLEN-1:0] imm_p1;
            logic [2:0]      f3_p1;
            logic [4:0]      rs1_p1;
            logic [4:0]      rs2_p1;
            logic [4:0]      rd_p1;

            // ID/EX: same flush/stall priority as IF/ID; flush inserts a zero bubble
            always_ff @(posedge clk or posedge rst) begin
                if (rst || flush_i) begin
                    vld_p1  <= 1'b0;
                    ctrl_p1 <= CTRL_NOP;
                    pc_p1   <= '0;
                    imm_p1  <= '0;
                    f3_p1   <= '0;
                    rs1_p1  <= '0;
                    rs2_p1  <= '0;
                    rd_p1   <= '0;
                end else if (!stall_i) begin
                    vld_p1  <= vld_p0;
                    ctrl_p1 <= ctrl_d;
                    pc_p1   <= pc_d;
                    imm_p1  <= imm_d;
                    f3_p1   <= f3_d;
                    rs1_p1  <= rs1_d;
                    rs2_p1  <= rs2_d;
                    rd_p1   <= rd_d;
                end
            end

            assign valid_o  = vld_p1;
            assign ctrl_o   = ctrl_p1;
            assign pc_o     = pc_p1;
            assign ImmExt   = imm_p1;
            assign funct3_o = f3_p1;
            assign rs1_o    = rs1_p1;
            assign rs2_o    = rs2_p1;
            assign rd_o     = rd_p1;
        end else begin : g_comb
            assign valid_o  = vld_p0;
            assign ctrl_o   = ctrl_d;
            assign pc_o     = pc_d;
            assign ImmExt   = imm_d;
            assign funct3_o = f3_d;
            assign rs1_o    = rs1_d;
            assign rs2_o    = rs2_d;
            assign rd_o     = rd_d;
        end
    endgenerate

    assign RegWrite  = ctrl_o.reg_write & valid_o;
    assign ALUctrl   = ctrl_o.alu_ctrl;
    assign ALUsrc    = ctrl_o.alu_src;
    assign ImmSrc    = ctrl_o.imm_src;
    assign ResultSrc = ctrl_o.result_src;
    assign MemWrite  = ctrl_o.mem_write & valid_o;
    assign Branch    = ctrl_o.branch & valid_o;
    assign Jump      = ctrl_o.jump & valid_o;
    assign illegal_o = ctrl_o.illegal & valid_o;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage (XLEN=32, OUT_REG=1) against a
// two-slot pipeline model with a table-driven RV32I/M decoder.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        valid_i, stall_i, flush_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        RegWrite;
    logic [4:0]  ALUctrl;
    logic        ALUsrc;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        MemWrite, Branch, Jump;
    logic [2:0]  funct3_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] ImmExt;
    logic        illegal_o;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .OUT_REG(1)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .instr_i(instr_i), .valid_i(valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .pc_o(pc_o),
        .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
        .ResultSrc(ResultSrc), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .ImmExt(ImmExt), .illegal_o(illegal_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        bit        rw, mw, br, jp, ill, asrc;
        bit [4:0]  aluc;
        bit [2:0]  isrc;
        bit [1:0]  rsrc;
        bit [31:0] imm;
        bit        chk_alu, chk_asrc, chk_imm;
    } exp_t;

    typedef struct {
        bit        v;
        bit [31:0] ins;
        bit [31:0] pc;
    } slot_t;

    slot_t s_if, s_ex;

    function automatic exp_t ref_dec(bit [31:0] w);
        exp_t     e;
        bit [6:0] op = w[6:0];
        bit [2:0] f3 = w[14:12];
        bit [6:0] f7 = w[31:25];
        int       s  = $signed(w);
        int       r_tab[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        int       imm_i = s >>> 20;
        int       imm_s = ((s >>> 25) <<< 5) | int'(w[11:7]);
        int       imm_b = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
        int       imm_u = int'(w & 32'hFFFFF000);
        int       imm_j = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
        e = '{default: 0};
        e.ill = 1;
        case (op)
            7'h33: begin
                if (f7 == 7'h00) begin e.ill = 0; e.aluc = 5'(r_tab[f3]); end
                else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin e.ill = 0; e.aluc = (f3 == 0) ? 5'd1 : 5'd7; end
`ifdef DECODE_MEXT_EN
                else if (f7 == 7'h01) begin e.ill = 0; e.aluc = 5'(16 + f3); end
`endif
                e.rw = !e.ill; e.chk_alu = 1; e.chk_asrc = 1; e.asrc = 0;
            end
            7'h13: begin
                e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
                e.aluc = (f3 == 5 && f7 == 7'h20) ? 5'd7 : 5'(r_tab[f3]);
                e.rw = 1; e.asrc = 1; e.isrc = 0; e.imm = imm_i;
                e.chk_alu = 1; e.chk_asrc = 1; e.chk_imm = 1;
            end
            7'h03: begin
                e.ill = 0; e.rw = 1; e.asrc = 1; e.rsrc = 1; e.aluc = 0; e.isrc = 0; e.imm = imm_i;
                e.chk_alu = 1; e.chk_asrc = 1; e.chk_imm = 1;
            end
            7'h23: begin
                e.ill = 0; e.mw = 1; e.asrc = 1; e.aluc = 0; e.isrc = 1; e.imm = imm_s;
                e.chk_alu = 1; e.chk_asrc = 1; e.chk_imm = 1;
            end
            7'h63: begin
                e.ill = (f3 == 2 || f3 == 3); e.br = 1; e.asrc = 0; e.isrc = 2; e.imm = imm_b;
                e.chk_asrc = 1; e.chk_imm = 1;
            end
            7'h6F: begin
                e.ill = 0; e.rw = 1; e.jp = 1; e.rsrc = 2; e.isrc = 4; e.imm = imm_j; e.chk_imm = 1;
            end
            7'h67: begin
                e.ill = 0; e.rw = 1; e.jp = 1; e.rsrc = 2; e.asrc = 1; e.aluc = 0; e.isrc = 0; e.imm = imm_i;
                e.chk_alu = 1; e.chk_asrc = 1; e.chk_imm = 1;
            end
            7'h37: begin
                e.ill = 0; e.rw = 1; e.asrc = 1; e.aluc = 10; e.isrc = 3; e.imm = imm_u;
                e.chk_alu = 1; e.chk_asrc = 1; e.chk_imm = 1;
            end
            7'h17: begin
                e.ill = 0; e.rw = 1; e.asrc = 1; e.aluc = 0; e.isrc = 3; e.imm = imm_u;
                e.chk_alu = 1; e.chk_asrc = 1; e.chk_imm = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.rw = 0; e.mw = 0; e.br = 0; e.jp = 0; end
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        if (!s_ex.v) begin
            check("bub_valid", valid_o, 0);
            check("bub_regwrite", RegWrite, 0);
            check("bub_memwrite", MemWrite, 0);
            check("bub_branch", Branch, 0);
            check("bub_jump", Jump, 0);
            check("bub_illegal", illegal_o, 0);
        end else begin
            e = ref_dec(s_ex.ins);
            check("valid", valid_o, 1);
            check("pc", pc_o, s_ex.pc);
            check("regwrite", RegWrite, e.rw);
            check("memwrite", MemWrite, e.mw);
            check("branch", Branch, e.br);
            check("jump", Jump, e.jp);
            check("illegal", illegal_o, e.ill);
            check("funct3", funct3_o, s_ex.ins[14:12]);
            check("rs1", rs1_o, s_ex.ins[19:15]);
            check("rs2", rs2_o, s_ex.ins[24:20]);
            check("rd", rd_o, s_ex.ins[11:7]);
            if (!e.ill) begin
                check("resultsrc", ResultSrc, e.rsrc);
                if (e.chk_alu)  check("aluctrl", ALUctrl, e.aluc);
                if (e.chk_asrc) check("alusrc", ALUsrc, e.asrc);
                if (e.chk_imm) begin
                    check("immsrc", ImmSrc, e.isrc);
                    check("immext", ImmExt, e.imm);
                end
            end
        end
    endtask

    // Inputs are applied at the falling edge; the model advances with the rising edge.
    task automatic step(input bit v, input bit [31:0] w, input bit [31:0] p, input bit st, input bit fl);
        valid_i = v; instr_i = w; pc_i = p; stall_i = st; flush_i = fl;
        @(posedge clk);
        if (fl) begin
            s_if.v = 0;
            s_ex.v = 0;
        end else if (!st) begin
            s_ex = s_if;
            s_if = '{v, w, p};
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] w = $urandom;
        bit [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        int        k = $urandom_range(0, 11);
        if (k < 9) begin
            w[6:0] = ops[k];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end else if (k == 10) begin
            w = 32'h0;
        end
        return w;
    endfunction

    task automatic rand_run(input int n);
        bit [31:0] pc = 32'h4000;
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), pc,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
            pc += 4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 0; instr_i = 0; pc_i = 0; stall_i = 0; flush_i = 0;
        s_if = '{0, 0, 0}; s_ex = '{0, 0, 0};
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_immext", ImmExt, 0);
        check("rst_aluctrl", ALUctrl, 0);
        rst = 1'b0;

        // addi x1,x0,5: visible two edges after presentation
        step(1, 32'h00500093, 32'h100, 0, 0);
        check("addi_lat1", valid_o, 0);
        step(0, 0, 0, 0, 0);
        check("addi_valid", valid_o, 1);
        check("addi_regwrite", RegWrite, 1);
        check("addi_alusrc", ALUsrc, 1);
        check("addi_aluctrl", ALUctrl, 0);
        check("addi_imm", ImmExt, 5);
        check("addi_rd", rd_o, 1);

        // beq x1,x2,-4
        step(1, 32'hFE208EE3, 32'h104, 0, 0);
        step(0, 0, 0, 0, 0);
        check("beq_branch", Branch, 1);
        check("beq_regwrite", RegWrite, 0);
        check("beq_immsrc", ImmSrc, 2);
        check("beq_imm", ImmExt, 32'hFFFFFFFC);
        check("beq_funct3", funct3_o, 0);

        // sw x2,8(x1) followed by a 3-cycle stall
        step(1, 32'h0020A423, 32'h108, 0, 0);
        step(1, 32'h00A00113, 32'h10C, 0, 0);
        check("sw_memwrite", MemWrite, 1);
        check("sw_imm", ImmExt, 8);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00000013, 32'h110, 1, 0);
            check("stall_memwrite", MemWrite, 1);
            check("stall_pc", pc_o, 32'h108);
            check("stall_imm", ImmExt, 8);
        end
        step(0, 0, 0, 0, 0);
        check("after_stall_pc", pc_o, 32'h10C);
        check("after_stall_regwrite", RegWrite, 1);

        // flush wins over stall
        step(1, 32'h0020A423, 32'h200, 0, 0);
        step(1, 32'h00500093, 32'h204, 0, 0);
        check("pre_flush_memwrite", MemWrite, 1);
        step(1, 32'h00500093, 32'h208, 1, 1);
        check("flush_valid", valid_o, 0);
        check("flush_memwrite", MemWrite, 0);
        step(0, 0, 0, 0, 0);
        check("flush_ifid_valid", valid_o, 0);

        // all-zero word
        step(1, 32'h00000000, 32'h300, 0, 0);
        step(0, 0, 0, 0, 0);
        check("zero_illegal", illegal_o, 1);
        check("zero_regwrite", RegWrite, 0);

        // mul x3,x1,x2
        step(1, 32'h022081B3, 32'h304, 0, 0);
        step(0, 0, 0, 0, 0);
`ifdef DECODE_MEXT_EN
        check("mul_aluctrl", ALUctrl, 16);
        check("mul_regwrite", RegWrite, 1);
        check("mul_illegal", illegal_o, 0);
`else
        check("mul_illegal", illegal_o, 1);
        check("mul_regwrite", RegWrite, 0);
`endif

        rand_run(200);

        // asynchronous reset pulse between clock edges
        step(1, 32'h00500093, 32'h500, 0, 0);
        step(1, 32'h00700113, 32'h504, 0, 0);
        check("pre_rst_valid", valid_o, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_pc", pc_o, 0);
        check("arst_regwrite", RegWrite, 0);
        check("arst_immext", ImmExt, 0);
        check("arst_rd", rd_o, 0);
        s_if = '{0, 0, 0}; s_ex = '{0, 0, 0};
        @(negedge clk);
        rst = 1'b0;

        rand_run(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
